h14tx_data_island_packer: RTL and testbench

H14TX_DATA_ISLAND_PACKER -- requirements
Module: h14tx_data_island_packer

---
 rtl/h14tx_pkg.sv | 8 +
 rtl/h14tx_data_island_packer.sv | 207 ++++++++++++++++++++
 tb/tb_h14tx_data_island_packer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/h14tx_pkg.sv
// -----------------------------------------------------------------------------
// h14tx_pkg
// Shared types for the HDMI 1.4 transmitter data path.
//   data_t : one TERC4 input nibble (4 bits) per TMDS channel
// -----------------------------------------------------------------------------
package h14tx_pkg;
  typedef logic [3:0] data_t;
endpackage

// File: rtl/h14tx_data_island_packer.sv
// -----------------------------------------------------------------------------
// h14tx_data_island_packer
// Serialises one HDMI data-island packet (24-bit header + four 56-bit
// subpackets) into 32 nibble periods for the three TERC4 channel encoders,
// computing and appending the BCH(x^8+x^7+x^6+1) ECC bytes on the fly.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   pkt_valid / pkt_ready    packet handshake; header/subpackets captured on
//                            the accepting edge
//   pkt_header[23:0]         HB0..HB2, bit 0 first
//   pkt_sub0..3[55:0]        subpacket bytes, bit 0 first
//   hsync, vsync             sync levels, carried on ch0 with one cycle latency
//   ch0/ch1/ch2_data         registered nibbles to the TERC4 encoders
//   di_active                nibble outputs carry packet content
//   di_first, di_last        nibble 0 / nibble 31 of a packet
//
// Configuration
//   H14TX_DI_BACK_TO_BACK_EN  when defined, a new packet may be accepted during
//                             nibble 31 and follows with no idle gap.
// -----------------------------------------------------------------------------
module h14tx_data_island_packer
  import h14tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [23:0] pkt_header,
  input  logic [55:0] pkt_sub0,
  input  logic [55:0] pkt_sub1,
  input  logic [55:0] pkt_sub2,
  input  logic [55:0] pkt_sub3,
  input  logic        hsync,
  input  logic        vsync,
  output data_t       ch0_data,
  output data_t       ch1_data,
  output data_t       ch2_data,
  output logic        di_active,
  output logic        di_first,
  output logic        di_last
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // One bit through the HDMI BCH LFSR (LSB-first shift, taps 8'h83).
  function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic b);
    logic fb;
    fb = b ^ ecc[0];
    return {1'b0, ecc[7:1]} ^ (fb ? 8'h83 : 8'h00);
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       k_q, k_d;
  logic [23:0]      hdr_q, hdr_d;
  logic [3:0][55:0] sub_q, sub_d;
  logic [7:0]       ecc_hdr_q, ecc_hdr_d;
  logic [3:0][7:0]  ecc_sub_q, ecc_sub_d;
  data_t            ch0_q, ch0_d;
  data_t            ch1_q, ch1_d;
  data_t            ch2_q, ch2_d;
  logic             active_q, active_d;
  logic             first_q, first_d;
  logic             last_q, last_d;

  logic             ready_s;
  logic             fire_s;
  logic             emit_s;
  logic [4:0]       idx_s;
  logic             hdr_bit_s;
  logic [3:0]       even_s;
  logic [3:0]       odd_s;
  logic [23:0]      src_hdr_s;
  logic [3:0][55:0] src_sub_s;
  logic [3:0][55:0] pkt_sub_s;
  logic [7:0]       src_ecc_hdr_s;
  logic [3:0][7:0]  src_ecc_sub_s;

  assign pkt_sub_s = {pkt_sub3, pkt_sub2, pkt_sub1, pkt_sub0};

`ifdef H14TX_DI_BACK_TO_BACK_EN
  assign ready_s = (state_q == ST_IDLE) || ((state_q == ST_SEND) && (k_q == 5'd31));
`else
  assign ready_s = (state_q == ST_IDLE);
`endif

  // Ready is gated by rst so nothing is offered while the block is held in reset.
  assign pkt_ready = ready_s & ~rst;
  assign fire_s    = pkt_valid & pkt_ready;
  // A nibble is loaded on every edge that starts a packet or advances one.
  assign emit_s    = fire_s | ((state_q == ST_SEND) && (k_q != 5'd31));

  // Next-state, ECC update and next nibble. On an accepting edge the sources
  // are the incoming packet with cleared LFSRs, so nibble 0 loads directly.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    hdr_d         = hdr_q;
    sub_d         = sub_q;
    ecc_hdr_d     = ecc_hdr_q;
    ecc_sub_d     = ecc_sub_q;
    ch0_d         = {2'b00, vsync, hsync};
    ch1_d         = 4'h0;
    ch2_d         = 4'h0;
    active_d      = 1'b0;
    first_d       = 1'b0;
    last_d        = 1'b0;
    hdr_bit_s     = 1'b0;
    even_s        = 4'h0;
    odd_s         = 4'h0;

    if (fire_s) begin
      idx_s         = 5'd0;
      src_hdr_s     = pkt_header;
      src_sub_s     = pkt_sub_s;
      src_ecc_hdr_s = 8'h00;
      src_ecc_sub_s = {4{8'h00}};
    end else begin
      idx_s         = k_q + 5'd1;
      src_hdr_s     = hdr_q;
      src_sub_s     = sub_q;
      src_ecc_hdr_s = ecc_hdr_q;
      src_ecc_sub_s = ecc_sub_q;
    end

    if (emit_s) begin
      state_d = ST_SEND;
      k_d     = idx_s;
      hdr_d   = src_hdr_s;
      sub_d   = src_sub_s;

      // Header: data bits for k<24, then the finished ECC byte LSB first.
      if (idx_s < 5'd24) begin
        hdr_bit_s = src_hdr_s[idx_s];
        ecc_hdr_d = ecc_step(src_ecc_hdr_s, hdr_bit_s);
      end else begin
        hdr_bit_s = src_ecc_hdr_s[idx_s[2:0]];
        ecc_hdr_d = src_ecc_hdr_s;
      end

      // Subpackets: two bits per nibble for k<28, then ECC in bit pairs.
      for (int i = 0; i < 4; i++) begin
        if (idx_s < 5'd28) begin
          even_s[i]    = src_sub_s[i][{idx_s, 1'b0}];
          odd_s[i]     = src_sub_s[i][{idx_s, 1'b1}];
          ecc_sub_d[i] = ecc_step(ecc_step(src_ecc_sub_s[i], even_s[i]), odd_s[i]);
        end else begin
          even_s[i]    = src_ecc_sub_s[i][{idx_s[1:0], 1'b0}];
          odd_s[i]     = src_ecc_sub_s[i][{idx_s[1:0], 1'b1}];
          ecc_sub_d[i] = src_ecc_sub_s[i];
        end
      end

      ch0_d    = {(idx_s != 5'd0), hdr_bit_s, vsync, hsync};
      ch1_d    = even_s;
      ch2_d    = odd_s;
      active_d = 1'b1;
      first_d  = (idx_s == 5'd0);
      last_d   = (idx_s == 5'd31);
    end else begin
      state_d = ST_IDLE;
      k_d     = 5'd0;
    end
  end

  // State, captured packet, LFSRs and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= 5'd0;
      hdr_q     <= 24'h000000;
      sub_q     <= {4{56'h0}};
      ecc_hdr_q <= 8'h00;
      ecc_sub_q <= {4{8'h00}};
      ch0_q     <= 4'h0;
      ch1_q     <= 4'h0;
      ch2_q     <= 4'h0;
      active_q  <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      hdr_q     <= hdr_d;
      sub_q     <= sub_d;
      ecc_hdr_q <= ecc_hdr_d;
      ecc_sub_q <= ecc_sub_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      ch2_q     <= ch2_d;
      active_q  <= active_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  assign ch0_data  = ch0_q;
  assign ch1_data  = ch1_q;
  assign ch2_data  = ch2_q;
  assign di_active = active_q;
  assign di_first  = first_q;
  assign di_last   = last_q;

endmodule

// File: tb/tb_h14tx_data_island_packer.sv
`timescale 1ns/1ps
module tb_h14tx_data_island_packer;
  import h14tx_pkg::*;

`ifdef H14TX_DI_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [23:0] pkt_header = 24'h0;
  logic [55:0] pkt_sub0 = 56'h0, pkt_sub1 = 56'h0, pkt_sub2 = 56'h0, pkt_sub3 = 56'h0;
  logic        hsync = 1'b0, vsync = 1'b0;
  data_t       ch0_data, ch1_data, ch2_data;
  logic        di_active, di_first, di_last;

  always #5 clk = ~clk;

  h14tx_data_island_packer dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_header(pkt_header), .pkt_sub0(pkt_sub0), .pkt_sub1(pkt_sub1),
    .pkt_sub2(pkt_sub2), .pkt_sub3(pkt_sub3), .hsync(hsync), .vsync(vsync),
    .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data),
    .di_active(di_active), .di_first(di_first), .di_last(di_last)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // BCH ECC over the first n bits of a stream, bit 0 first.
  function automatic logic [7:0] bch_ecc(input logic [55:0] bits, input int n);
    logic [7:0] e;
    logic fb;
    e = 8'h00;
    for (int j = 0; j < n; j++) begin
      fb = bits[j] ^ e[0];
      e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  function automatic logic [55:0] rnd56();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[55:0];
  endfunction

  function automatic logic [23:0] rnd24();
    logic [31:0] v;
    v = $urandom;
    return v[23:0];
  endfunction

  // ---------------- reference model ----------------
  // Each accepted packet becomes a 32-bit header stream and four 64-bit
  // subpacket streams (data followed by ECC); nibble k reads positions k / 2k,2k+1.
  logic [31:0] t_hdr;
  logic [63:0] t_sub [4];
  bit    m_busy = 1'b0;
  int    m_k = 0;
  int    m_acc = 0;
  bit    chk_en = 1'b0;
  data_t e_ch0 = 4'h0, e_ch1 = 4'h0, e_ch2 = 4'h0;
  bit    e_act = 1'b0, e_first = 1'b0, e_last = 1'b0;

  always @(posedge clk) begin
    bit rdy;
    bit fire;
    if (rst) begin
      m_busy = 1'b0; m_k = 0;
      e_ch0 = 4'h0; e_ch1 = 4'h0; e_ch2 = 4'h0;
      e_act = 1'b0; e_first = 1'b0; e_last = 1'b0;
      chk_en = 1'b1;
    end else begin
      rdy  = !m_busy || (B2B && m_k == 31);
      fire = pkt_valid && rdy;
      if (fire) begin
        t_hdr    = {bch_ecc({32'h0, pkt_header}, 24), pkt_header};
        t_sub[0] = {bch_ecc(pkt_sub0, 56), pkt_sub0};
        t_sub[1] = {bch_ecc(pkt_sub1, 56), pkt_sub1};
        t_sub[2] = {bch_ecc(pkt_sub2, 56), pkt_sub2};
        t_sub[3] = {bch_ecc(pkt_sub3, 56), pkt_sub3};
        m_busy = 1'b1; m_k = 0; m_acc++;
      end else if (m_busy && m_k < 31) begin
        m_k++;
      end else begin
        m_busy = 1'b0; m_k = 0;
      end
      if (m_busy) begin
        e_ch0 = {(m_k != 0), t_hdr[m_k], vsync, hsync};
        for (int i = 0; i < 4; i++) begin
          e_ch1[i] = t_sub[i][2*m_k];
          e_ch2[i] = t_sub[i][2*m_k+1];
        end
        e_act = 1'b1; e_first = (m_k == 0); e_last = (m_k == 31);
      end else begin
        e_ch0 = {2'b00, vsync, hsync}; e_ch1 = 4'h0; e_ch2 = 4'h0;
        e_act = 1'b0; e_first = 1'b0; e_last = 1'b0;
      end
    end
  end

  // Every cycle: DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("ch0", ch0_data, e_ch0);
      check_eq("ch1", ch1_data, e_ch1);
      check_eq("ch2", ch2_data, e_ch2);
      check_eq("di_active", di_active, e_act);
      check_eq("di_first", di_first, e_first);
      check_eq("di_last", di_last, e_last);
      check_eq("pkt_ready", pkt_ready, (!rst && (!m_busy || (B2B && m_k == 31))));
    end
  end

  // Random sync levels when enabled.
  bit rand_sync = 1'b0;
  always @(posedge clk) begin
    if (rand_sync) begin
      #1;
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  data_t obs_ch0 [32];
  data_t obs_ch1 [32];
  data_t obs_ch2 [32];
  bit    act_v [80];
  bit    first_v [80];
  bit    last_v [80];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                         input logic [55:0] s2, input logic [55:0] s3);
    pkt_header = h; pkt_sub0 = s0; pkt_sub1 = s1; pkt_sub2 = s2; pkt_sub3 = s3;
  endtask

  task automatic set_rand_pkt();
    set_pkt(rnd24(), rnd56(), rnd56(), rnd56(), rnd56());
  endtask

  // Offer a packet and wait (bounded) for the accepting edge; inputs are
  // scrambled afterwards since they need not stay stable.
  task automatic send_pkt(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                          input logic [55:0] s2, input logic [55:0] s3);
    int start;
    bit got;
    set_pkt(h, s0, s1, s2, s3);
    pkt_valid = 1'b1;
    start = m_acc;
    for (int c = 0; c < 200 && m_acc == start; c++) tick();
    got = (m_acc != start);
    check_eq("accept", got, 1);
    pkt_valid = 1'b0;
    set_rand_pkt();
  endtask

  task automatic capture32();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      obs_ch0[k] = ch0_data; obs_ch1[k] = ch1_data; obs_ch2[k] = ch2_data;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [8:0]  want_h;
    logic [55:0] s_bit55;
    int s, run1, gap, run2, start, j;
    bit changed;

    // Reset with sync inputs high: everything must read zero.
    hsync = 1'b1; vsync = 1'b1; rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_ch0", ch0_data, 4'h0);
    check_eq("rst_active", di_active, 1'b0);
    check_eq("rst_ready", pkt_ready, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", pkt_ready, 1'b1);

    // All-zero packet, hsync=1 vsync=0.
    tick();
    hsync = 1'b1; vsync = 1'b0;
    tick();
    send_pkt(24'h0, 56'h0, 56'h0, 56'h0, 56'h0);
    capture32();
    for (int k = 0; k < 32; k++) begin
      check_eq("zero_ch0", obs_ch0[k], (k == 0) ? 4'h1 : 4'h9);
      check_eq("zero_ch12", {obs_ch1[k], obs_ch2[k]}, 8'h00);
    end

    // Header bit 23 only: ECC 8'h83.
    tick();
    send_pkt(24'h800000, 56'h0, 56'h0, 56'h0, 56'h0);
    capture32();
    want_h = 9'b1_0000_0111;
    for (int k = 23; k < 32; k++) check_eq("hdr_ecc_bit", obs_ch0[k][2], want_h[k-23]);

    // Subpacket 0 bit 55 only.
    tick();
    s_bit55 = 56'h0;
    s_bit55[55] = 1'b1;
    send_pkt(24'h0, s_bit55, 56'h0, 56'h0, 56'h0);
    capture32();
    check_eq("sub_k27_odd", obs_ch2[27][0], 1'b1);
    check_eq("sub_k28_even", obs_ch1[28][0], 1'b1);
    check_eq("sub_k28_odd", obs_ch2[28][0], 1'b1);
    check_eq("sub_k29", {obs_ch1[29][0], obs_ch2[29][0]}, 2'b00);
    check_eq("sub_k30", {obs_ch1[30][0], obs_ch2[30][0]}, 2'b00);
    check_eq("sub_k31_even", obs_ch1[31][0], 1'b0);
    check_eq("sub_k31_odd", obs_ch2[31][0], 1'b1);

    // pkt_valid held through two packets.
    tick();
    set_rand_pkt();
    pkt_valid = 1'b1;
    start = m_acc;
    changed = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      act_v[c] = di_active; first_v[c] = di_first; last_v[c] = di_last;
      @(posedge clk);
      #1;
      if (m_acc == start + 1 && !changed) begin
        set_rand_pkt();
        changed = 1'b1;
      end
      if (m_acc >= start + 2) pkt_valid = 1'b0;
    end
    pkt_valid = 1'b0;
    s = 0;
    while (s < 79 && !act_v[s]) s++;
    run1 = 0; j = s;
    while (j < 80 && act_v[j]) begin run1++; j++; end
    gap = 0;
    while (j < 80 && !act_v[j]) begin gap++; j++; end
    run2 = 0;
    while (j < 80 && act_v[j]) begin run2++; j++; end
`ifdef H14TX_DI_BACK_TO_BACK_EN
    check_eq("b2b_run", run1, 64);
    check_eq("b2b_last", last_v[s+31], 1'b1);
    check_eq("b2b_first", first_v[s+32], 1'b1);
`else
    check_eq("gap_run1", run1, 32);
    check_eq("gap_len", gap, 1);
    check_eq("gap_run2", run2, 32);
`endif

    // Reset at k=10 aborts the packet.
    repeat (3) tick();
    hsync = 1'b1; vsync = 1'b1;
    send_pkt(rnd24(), rnd56(), rnd56(), rnd56(), rnd56());
    repeat (10) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("abort_ch", {ch0_data, ch1_data, ch2_data}, 12'h000);
    check_eq("abort_flags", {di_active, di_first, di_last, pkt_ready}, 4'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", pkt_ready, 1'b1);
    check_eq("abort_idle", di_active, 1'b0);
    tick();
    send_pkt(rnd24(), rnd56(), rnd56(), rnd56(), rnd56());
    capture32();

    // pkt_valid pulse mid-packet must not be captured.
    tick();
    send_pkt(rnd24(), rnd56(), rnd56(), rnd56(), rnd56());
    repeat (5) tick();
    set_rand_pkt();
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    repeat (30) tick();

    // Randomized traffic with random sync, gaps, stray pulses and resets.
    rand_sync = 1'b1;
    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_pkt(rnd24(), rnd56(), rnd56(), rnd56(), rnd56());
      case ($urandom_range(0, 7))
        0: begin
          repeat ($urandom_range(1, 30)) tick();
          rst = 1'b1;
          tick();
          rst = 1'b0;
        end
        1: begin
          repeat ($urandom_range(1, 25)) tick();
          set_rand_pkt();
          pkt_valid = 1'b1;
          tick();
          pkt_valid = 1'b0;
        end
        default: repeat ($urandom_range(0, 31)) tick();
      endcase
    end
    repeat (40) tick();
    rand_sync = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
